multi_measure: RTL and testbench

MULTI_MEASURE -- requirements
Module: multi_measure

---
 rtl/measure_pkg.sv | 12 +
 rtl/meas_chan.sv | 93 +++++++++
 rtl/multi_measure.sv | 89 ++++++++
 tb/tb_multi_measure.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/measure_pkg.sv
// measure_pkg: channel state encoding, result record and defaults shared by multi_measure.
package measure_pkg;
    localparam int RES_W = 64;
    localparam int DEFAULT_GATE_TIME = 1000;
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_GATE, ST_DONE} chan_state_e;
    typedef struct packed {
        logic [RES_W-1:0] sig_cnt;
        logic [RES_W-1:0] ref_cnt;
        logic [RES_W-1:0] high_cnt;
        logic             ovf;
    } meas_res_t;
endpackage

// File: rtl/meas_chan.sv
// meas_chan: one measurement channel (synchronizer, edge detect, gate FSM, counters).
// MULTI_MEASURE_DUTY_EN adds the signal-high cycle counter.
module meas_chan
    import measure_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             ref_clk_i,
    input  logic             ref_rst_n_i,
    input  logic             sig_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cont_i,
    input  logic             grant_i,
    input  logic [CNT_W-1:0] gate_time_i,
    output logic             done_o,
    output logic             idle_o,
    output meas_res_t        res_o
);
    chan_state_e      state_q, state_d;
    logic [2:0]       sync_q;
    logic             edge_q, ovf_q, ovf_d;
    logic [CNT_W-1:0] gate_q, gate_d, sig_q, sig_d, ref_q, ref_d, ref_inc;

    always_ff @(posedge ref_clk_i or negedge ref_rst_n_i) begin
        if (!ref_rst_n_i) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            state_q <= ST_IDLE;
            gate_q  <= '0;
            sig_q   <= '0;
            ref_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], sig_i};
            edge_q  <= sync_q[1] & ~sync_q[2];
            state_q <= state_d;
            gate_q  <= gate_d;
            sig_q   <= sig_d;
            ref_q   <= ref_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        sig_d   = sig_q;
        ref_d   = ref_q;
        ovf_d   = ovf_q;
        ref_inc = (&ref_q) ? ref_q : ref_q + CNT_W'(1);
        if (abort_i) state_d = ST_IDLE;
        else case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_ARM;
                gate_d  = (gate_time_i == '0) ? CNT_W'(1) : gate_time_i;
            end
            ST_ARM: if (edge_q) begin
                state_d = ST_GATE;
                sig_d   = '0;
                ref_d   = '0;
                ovf_d   = 1'b0;
            end
            ST_GATE: begin
                ref_d = ref_inc;
                sig_d = sig_q + CNT_W'(edge_q);
                ovf_d = &ref_inc;
                // saturation ends the gate even without a closing edge
                if (&ref_inc || (edge_q && ref_inc >= gate_q)) state_d = ST_DONE;
            end
            default: if (grant_i) state_d = cont_i ? ST_ARM : ST_IDLE;
        endcase
    end

`ifdef MULTI_MEASURE_DUTY_EN
    logic [CNT_W-1:0] high_q;
    // sync_q[2] is the level aligned with edge_q
    always_ff @(posedge ref_clk_i or negedge ref_rst_n_i) begin
        if (!ref_rst_n_i) high_q <= '0;
        else if (state_q == ST_ARM && edge_q && !abort_i) high_q <= '0;
        else if (state_q == ST_GATE && !abort_i) high_q <= high_q + CNT_W'(sync_q[2]);
    end
    assign res_o.high_cnt = RES_W'(high_q);
`else
    assign res_o.high_cnt = '0;
`endif

    assign res_o.sig_cnt = RES_W'(sig_q);
    assign res_o.ref_cnt = RES_W'(ref_q);
    assign res_o.ovf     = ovf_q;
    assign done_o        = state_q == ST_DONE;
    assign idle_o        = state_q == ST_IDLE;
endmodule

// File: rtl/multi_measure.sv
// multi_measure: CH_NUM-channel period/frequency counter with round-robin result output.
// MULTI_MEASURE_DUTY_EN enables signal-high time reporting on res_high_o.
module multi_measure
    import measure_pkg::*;
#(
    parameter  int CH_NUM = 4,
    parameter  int CNT_W  = 32,
    localparam int CH_W   = CH_NUM > 1 ? $clog2(CH_NUM) : 1
) (
    input  logic              ref_clk_i,
    input  logic              ref_rst_n_i,
    input  logic [CH_NUM-1:0] sig_clk_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              cont_i,
    input  logic [CNT_W-1:0]  gate_time_i,
    output logic              busy_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CH_W-1:0]   res_ch_o,
    output logic [CNT_W-1:0]  res_sig_o,
    output logic [CNT_W-1:0]  res_ref_o,
    output logic [CNT_W-1:0]  res_high_o,
    output logic              res_ovf_o
);
    logic [CH_NUM-1:0] req, idle, grant;
    meas_res_t         chan_res [CH_NUM];
    meas_res_t         res_q;
    logic [CH_W-1:0]   last_q, gnt_idx, ch_q;
    logic              valid_q, load, unused_res;

    genvar i;
    for (i = 0; i < CH_NUM; i++) begin : g_chan
        meas_chan #(.CNT_W(CNT_W)) u_chan (
            .ref_clk_i  (ref_clk_i),
            .ref_rst_n_i(ref_rst_n_i),
            .sig_i      (sig_clk_i[i]),
            .start_i    (start_i),
            .abort_i    (abort_i),
            .cont_i     (cont_i),
            .grant_i    (grant[i]),
            .gate_time_i(gate_time_i),
            .done_o     (req[i]),
            .idle_o     (idle[i]),
            .res_o      (chan_res[i])
        );
    end

    // lowest requester above last_q wins, else lowest overall
    always_comb begin
        gnt_idx = last_q;
        for (int k = CH_NUM - 1; k >= 0; k--) if (req[k]) gnt_idx = CH_W'(k);
        for (int k = CH_NUM - 1; k >= 0; k--) if (req[k] && k > int'(last_q)) gnt_idx = CH_W'(k);
    end

    assign load  = ~valid_q | res_ready_i;
    assign grant = (load && !abort_i && |req) ? CH_NUM'(1) << gnt_idx : '0;

    always_ff @(posedge ref_clk_i or negedge ref_rst_n_i) begin
        if (!ref_rst_n_i) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            ch_q    <= '0;
            last_q  <= CH_W'(CH_NUM - 1);
        end else if (abort_i) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= |req;
            if (|req) begin
                res_q  <= chan_res[gnt_idx];
                ch_q   <= gnt_idx;
                last_q <= gnt_idx;
            end
        end
    end

    assign busy_o      = ~&idle | valid_q;
    assign res_valid_o = valid_q;
    assign res_ch_o    = ch_q;
    assign res_sig_o   = res_q.sig_cnt[CNT_W-1:0];
    assign res_ref_o   = res_q.ref_cnt[CNT_W-1:0];
    assign res_ovf_o   = res_q.ovf;
    assign unused_res  = ^res_q;
`ifdef MULTI_MEASURE_DUTY_EN
    assign res_high_o  = res_q.high_cnt[CNT_W-1:0];
`else
    assign res_high_o  = '0;
`endif
endmodule

// File: tb/tb_multi_measure.sv
// tb_multi_measure: directed checks of multi_measure (4x32-bit instance and 1x8-bit instance).
module tb_multi_measure;
    import measure_pkg::*;
`ifdef MULTI_MEASURE_DUTY_EN
    localparam int EXP_HIGH = 300;
`else
    localparam int EXP_HIGH = 0;
`endif
    logic        clk = 0, rst_n = 0, gen_sig = 0;
    logic        start = 0, abort = 0, cont = 0, ready = 0;
    logic [31:0] gate = 0;
    logic        busy, valid, ovf;
    logic [1:0]  ch;
    logic [31:0] rsig, rref, rhigh;
    logic        b_sig = 0, b_start = 0, b_busy, b_valid, b_ovf;
    logic [0:0]  b_ch;
    logic [7:0]  b_gate = 0, b_rsig, b_rref, b_rhigh;
    int          checks = 0, errors = 0;
    int          per = 10, hi = 3, ph = 0;
    bit          sig_en = 0;
    logic [3:0]  mask;
    bit          seen;

    always #5 clk = ~clk;

    multi_measure #(.CH_NUM(4), .CNT_W(32)) dut (
        .ref_clk_i(clk), .ref_rst_n_i(rst_n), .sig_clk_i({4{gen_sig}}),
        .start_i(start), .abort_i(abort), .cont_i(cont), .gate_time_i(gate),
        .busy_o(busy), .res_valid_o(valid), .res_ready_i(ready), .res_ch_o(ch),
        .res_sig_o(rsig), .res_ref_o(rref), .res_high_o(rhigh), .res_ovf_o(ovf)
    );

    multi_measure #(.CH_NUM(1), .CNT_W(8)) dut8 (
        .ref_clk_i(clk), .ref_rst_n_i(rst_n), .sig_clk_i(b_sig),
        .start_i(b_start), .abort_i(abort), .cont_i(cont), .gate_time_i(b_gate),
        .busy_o(b_busy), .res_valid_o(b_valid), .res_ready_i(ready), .res_ch_o(b_ch),
        .res_sig_o(b_rsig), .res_ref_o(b_rref), .res_high_o(b_rhigh), .res_ovf_o(b_ovf)
    );

    // periodic test signal: high for hi cycles out of per
    initial forever begin
        @(posedge clk);
        #2;
        if (!sig_en) begin
            ph = 0;
            gen_sig = 0;
        end else begin
            gen_sig = ph < hi;
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!valid) chk("timeout", valid, 1);
    endtask

    initial begin
        gate = DEFAULT_GATE_TIME;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst valid", valid, 0);
        chk("rst ch", ch, 0);
        chk("rst sig", rsig, 0);
        chk("rst ref", rref, 0);
        chk("rst high", rhigh, 0);
        chk("rst ovf", ovf, 0);
        chk("rst b_busy", b_busy, 0);
        chk("rst b_valid", b_valid, 0);
        chk("rst b_ref", b_rref, 0);
        rst_n = 1;
        ready = 1;
        sig_en = 1;

        pulse_start();
        wait_valid(3000);
        chk("p10 ch", ch, 0);
        chk("p10 sig", rsig, 100);
        chk("p10 ref", rref, 1000);
        chk("p10 high", rhigh, EXP_HIGH);
        chk("p10 ovf", ovf, 0);
        @(negedge clk) chk("p10 ch1", ch, 1);
        @(negedge clk) chk("p10 ch2", ch, 2);
        @(negedge clk) chk("p10 ch3", ch, 3);
        @(negedge clk) chk("p10 valid end", valid, 0);
        chk("p10 busy end", busy, 0);

        per = 7;
        repeat (20) @(negedge clk);
        pulse_start();
        wait_valid(3000);
        chk("p7 sig", rsig, 143);
        chk("p7 ref", rref, 1001);
        repeat (4) @(negedge clk);
        chk("p7 busy end", busy, 0);

        per = 10;
        gate = 0;
        repeat (20) @(negedge clk);
        pulse_start();
        wait_valid(200);
        chk("g0 sig", rsig, 1);
        chk("g0 ref", rref, 10);
        repeat (4) @(negedge clk);

        ready = 0;
        gate = 100;
        cont = 1;
        pulse_start();
        wait_valid(500);
        chk("rr ch0", ch, 0);
        chk("rr sig", rsig, 10);
        repeat (5) @(negedge clk);
        chk("hold valid", valid, 1);
        chk("hold ch", ch, 0);
        chk("hold ref", rref, 100);
        ready = 1;
        @(negedge clk) chk("rr ch1", ch, 1);
        @(negedge clk) chk("rr ch2", ch, 2);
        @(negedge clk) chk("rr ch3", ch, 3);
        cont = 0;
        mask = 0;
        for (int r = 0; r < 4; r++) begin
            wait_valid(500);
            mask[ch] = 1'b1;
            chk("r2 sig", rsig, 10);
            chk("r2 ref", rref, 100);
            @(negedge clk);
        end
        chk("r2 mask", mask, 4'hf);
        repeat (2) @(negedge clk);
        chk("r2 busy end", busy, 0);

        @(negedge clk) begin start = 1; abort = 1; end
        @(negedge clk) begin start = 0; abort = 0; end
        chk("abort wins", busy, 0);

        gate = 1000;
        pulse_start();
        repeat (200) @(negedge clk);
        chk("gate busy", busy, 1);
        @(negedge clk) abort = 1;
        @(negedge clk) abort = 0;
        chk("abort busy", busy, 0);
        chk("abort valid", valid, 0);
        seen = 0;
        repeat (1500) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        chk("abort no result", seen, 0);

        b_gate = 200;
        @(negedge clk) b_start = 1;
        @(negedge clk) b_start = 0;
        repeat (3) @(negedge clk);
        b_sig = 1;
        for (int n = 0; n < 400 && !b_valid; n++) @(negedge clk);
        chk("w8 valid", b_valid, 1);
        chk("w8 ref", b_rref, 255);
        chk("w8 sig", b_rsig, 0);
        chk("w8 ovf", b_ovf, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
